// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares the SDRAM controller command port between three
// requesters. Port 0 (VGA) has absolute priority; ports 1 (CPU) and 2 (DMA)
// share what remains. A grant owns the controller from command issue until
// the controller reports m_done.
//
// Build option: define SDRAM_ARB_RR_EN to make ports 1 and 2 round-robin.
// Without it, fixed priority port 0 > port 1 > port 2 applies.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no burst; pick a winner from req and latch its command
// ISSUE | m_req high with a stable registered command, waiting for m_ack
// BUSY  | command accepted, burst in progress until m_done
module sdram_port_arb #(
    parameter int AW = 24,
    parameter int LW = 8,
    parameter int DW = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*LW-1:0] len,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [2:0]      wnext,
    output logic [DW-1:0]   rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [LW-1:0]   m_len,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_ack,
    input  logic            m_rvalid,
    input  logic            m_wnext,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_owner;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_len;
    logic            r_m_req;
    logic [2:0]      r_gnt;

    logic [1:0]      w_win;
    logic            w_load;
    logic            w_accept;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [LW-1:0]   w_sel_len;
    logic [DW-1:0]   w_own_wdata;
    logic [2:0]      w_own_mask;

`ifdef SDRAM_ARB_RR_EN
    // 0: port 1 preferred when ports 1 and 2 both request, 1: port 2 preferred
    logic            r_ptr;
`endif

    // Winner selection among the current requests
    always_comb begin
        w_win = 2'd0;
        if (req[0]) begin
            w_win = 2'd0;
`ifdef SDRAM_ARB_RR_EN
        end else if (req[1] && req[2]) begin
            w_win = r_ptr ? 2'd2 : 2'd1;
`endif
        end else if (req[1]) begin
            w_win = 2'd1;
        end else if (req[2]) begin
            w_win = 2'd2;
        end
    end

    // Command fields of the winning port
    always_comb begin
        w_sel_we   = we[0];
        w_sel_addr = addr[0 +: AW];
        w_sel_len  = len[0 +: LW];
        case (w_win)
            2'd1: begin
                w_sel_we   = we[1];
                w_sel_addr = addr[AW +: AW];
                w_sel_len  = len[LW +: LW];
            end
            2'd2: begin
                w_sel_we   = we[2];
                w_sel_addr = addr[2*AW +: AW];
                w_sel_len  = len[2*LW +: LW];
            end
            default: begin
                w_sel_we   = we[0];
                w_sel_addr = addr[0 +: AW];
                w_sel_len  = len[0 +: LW];
            end
        endcase
    end

    // Write data of the current owner
    always_comb begin
        case (r_owner)
            2'd1:    w_own_wdata = wdata[DW +: DW];
            2'd2:    w_own_wdata = wdata[2*DW +: DW];
            default: w_own_wdata = wdata[0 +: DW];
        endcase
    end

    assign w_own_mask = 3'b001 << r_owner;

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus load/accept strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ack) begin
                    w_accept    = 1'b1;
                    // a burst may finish in the same cycle it is accepted
                    w_state_nxt = m_done ? ST_IDLE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command registers, owner, m_req and the registered grant pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_owner <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_m_req <= 1'b0;
            r_gnt   <= 3'b000;
        end else begin
            r_gnt <= w_accept ? w_own_mask : 3'b000;
            if (w_load) begin
                r_owner <= w_win;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_len   <= w_sel_len;
                r_m_req <= 1'b1;
            end else if (w_accept) begin
                r_m_req <= 1'b0;
            end
        end
    end

`ifdef SDRAM_ARB_RR_EN
    // Round-robin pointer: after a port 1 or port 2 grant, prefer the other one
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_accept && (r_owner != 2'd0)) begin
            r_ptr <= (r_owner == 2'd1);
        end
    end
`endif

    // Data-phase routing to the owner; strobes arriving in IDLE are dropped
    always_comb begin
        rvalid  = 3'b000;
        wnext   = 3'b000;
        m_wdata = '0;
        if (r_state != ST_IDLE) begin
            rvalid  = m_rvalid ? w_own_mask : 3'b000;
            wnext   = m_wnext ? w_own_mask : 3'b000;
            m_wdata = w_own_wdata;
        end
    end

    assign gnt    = r_gnt;
    assign m_req  = r_m_req;
    assign m_we   = r_we;
    assign m_addr = r_addr;
    assign m_len  = r_len;
    assign rdata  = m_rdata;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Testbench for sdram_port_arb. The bench plays both the three requesters
// and the SDRAM controller. Expected grants and data words are queued when
// the stimulus is set up and popped when the arbiter produces them.
module tb_sdram_port_arb;
    localparam int AW = 24;
    localparam int LW = 8;
    localparam int DW = 16;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*LW-1:0] len;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [2:0]      wnext;
    logic [DW-1:0]   rdata;
    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic [DW-1:0]   m_wdata;
    logic            m_ack;
    logic            m_rvalid;
    logic            m_wnext;
    logic [DW-1:0]   m_rdata;
    logic            m_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]    mask;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] gq[$];

    sdram_port_arb #(.AW(AW), .LW(LW), .DW(DW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .len       (len),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .wnext     (wnext),
        .rdata     (rdata),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_len     (m_len),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rvalid  (m_rvalid),
        .m_wnext   (m_wnext),
        .m_rdata   (m_rdata),
        .m_done    (m_done)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of tests");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pop_grant(output logic [2:0] g);
        g = 3'b000;
        if (gq.size() != 0) g = gq.pop_front();
    endtask

    task automatic pop_word(output exp_t e);
        e.mask = 3'b000;
        e.data = '0;
        if (sb.size() != 0) e = sb.pop_front();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        req = '0; we = '0; addr = '0; len = '0; wdata = '0;
        m_ack = 1'b0; m_rvalid = 1'b0; m_wnext = 1'b0; m_done = 1'b0;
        m_rdata = 16'h5A5A;
        #2;
        n_vec++;
        if ({gnt, rvalid, wnext} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_strobes: got %h required 000", {gnt, rvalid, wnext});
        end
        n_vec++;
        if ({m_req, m_we, m_addr, m_len, m_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_cmd: got req=%b we=%b addr=%h len=%h wdata=%h required all 0",
                     m_req, m_we, m_addr, m_len, m_wdata);
        end
        n_vec++;
        if (rdata !== 16'h5A5A) begin
            n_err++;
            $display("FAIL reset_rdata: got %h required 5a5a", rdata);
        end
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        n_vec++;
        if (m_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_mreq: got %b required 0", m_req);
        end
    endtask

    task automatic test_priority();
        logic [2:0]    g;
        logic [AW-1:0] third_addr;
`ifdef SDRAM_ARB_RR_EN
        third_addr = 24'h000030;
        gq.push_back(3'b001); gq.push_back(3'b010); gq.push_back(3'b100);
`else
        third_addr = 24'h000020;
        gq.push_back(3'b001); gq.push_back(3'b010); gq.push_back(3'b010);
`endif
        we   = 3'b000;
        addr = {24'h000030, 24'h000020, 24'h000010};
        len  = {8'd1, 8'd1, 8'd1};
        req  = 3'b111;
        tick();
        n_vec++;
        if ({m_req, m_addr} !== {1'b1, 24'h000010}) begin
            n_err++;
            $display("FAIL prio_first_cmd: got req=%b addr=%h required 1 000010", m_req, m_addr);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL prio_gnt0: got %b required %b", gnt, g);
        end
        req[0] = 1'b0;
        m_done = 1'b1; tick(); m_done = 1'b0;
        n_vec++;
        if (m_req !== 1'b0) begin
            n_err++;
            $display("FAIL prio_dead_cycle: got m_req=%b required 0", m_req);
        end
        tick();
        n_vec++;
        if ({m_req, m_addr} !== {1'b1, 24'h000020}) begin
            n_err++;
            $display("FAIL prio_second_cmd: got req=%b addr=%h required 1 000020", m_req, m_addr);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL prio_gnt1: got %b required %b", gnt, g);
        end
        // port 1 keeps requesting for another burst
        m_done = 1'b1; tick(); m_done = 1'b0;
        tick();
        n_vec++;
        if ({m_req, m_addr} !== {1'b1, third_addr}) begin
            n_err++;
            $display("FAIL prio_third_cmd: got req=%b addr=%h required 1 %h", m_req, m_addr, third_addr);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL prio_gnt2: got %b required %b", gnt, g);
        end
        req = 3'b000;
        m_done = 1'b1; tick(); m_done = 1'b0;
    endtask

    task automatic test_read();
        logic [2:0] g;
        exp_t       e;
        we = 3'b000;
        addr[AW +: AW] = 24'h000100;
        len[LW +: LW]  = 8'd4;
        req = 3'b010;
        gq.push_back(3'b010);
        for (int i = 0; i < 4; i++) sb.push_back('{3'b010, 16'hA001 + 16'(i)});
        tick();
        n_vec++;
        if ({m_req, m_we, m_addr, m_len} !== {1'b1, 1'b0, 24'h000100, 8'd4}) begin
            n_err++;
            $display("FAIL read_cmd: got req=%b we=%b addr=%h len=%h required 1 0 000100 04",
                     m_req, m_we, m_addr, m_len);
        end
        tick();
        n_vec++;
        if ({m_req, gnt} !== 4'b1000) begin
            n_err++;
            $display("FAIL read_hold: got req=%b gnt=%b required 1 000", m_req, gnt);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if ({gnt, m_req} !== {g, 1'b0}) begin
            n_err++;
            $display("FAIL read_gnt: got gnt=%b req=%b required %b 0", gnt, m_req, g);
        end
        req[1] = 1'b0;
        tick();
        n_vec++;
        if (gnt !== 3'b000) begin
            n_err++;
            $display("FAIL read_gnt_pulse: got %b required 000", gnt);
        end
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = 16'hA001 + 16'(i);
            #1;
            pop_word(e);
            n_vec++;
            if ({rvalid, rdata} !== {e.mask, e.data}) begin
                n_err++;
                $display("FAIL read_word%0d: got rvalid=%b rdata=%h required %b %h",
                         i, rvalid, rdata, e.mask, e.data);
            end
            tick();
        end
        m_rvalid = 1'b0;
        m_done = 1'b1; tick(); m_done = 1'b0;
    endtask

    task automatic test_idle_strobe();
        req = 3'b000;
        m_rvalid = 1'b1;
        m_wnext  = 1'b1;
        m_rdata  = 16'hCCCC;
        #1;
        n_vec++;
        if ({rvalid, wnext, m_wdata} !== '0) begin
            n_err++;
            $display("FAIL idle_strobe: got rvalid=%b wnext=%b wdata=%h required 0",
                     rvalid, wnext, m_wdata);
        end
        tick();
        n_vec++;
        if ({gnt, m_req, rvalid} !== 7'b0) begin
            n_err++;
            $display("FAIL idle_strobe_after: got gnt=%b req=%b rvalid=%b required 0", gnt, m_req, rvalid);
        end
        m_rvalid = 1'b0;
        m_wnext  = 1'b0;
    endtask

    task automatic test_write();
        logic [2:0] g;
        exp_t       e;
        we = 3'b100;
        addr[2*AW +: AW] = 24'h000040;
        len[2*LW +: LW]  = 8'd3;
        wdata[2*DW +: DW] = 16'h1111;
        req = 3'b100;
        gq.push_back(3'b100);
        sb.push_back('{3'b100, 16'h1111});
        sb.push_back('{3'b100, 16'h2222});
        sb.push_back('{3'b100, 16'h3333});
        tick();
        n_vec++;
        if ({m_req, m_we, m_addr, m_len} !== {1'b1, 1'b1, 24'h000040, 8'd3}) begin
            n_err++;
            $display("FAIL write_cmd: got req=%b we=%b addr=%h len=%h required 1 1 000040 03",
                     m_req, m_we, m_addr, m_len);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL write_gnt: got %b required %b", gnt, g);
        end
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_wnext = 1'b1;
            #1;
            pop_word(e);
            n_vec++;
            if ({wnext, m_wdata} !== {e.mask, e.data}) begin
                n_err++;
                $display("FAIL write_word%0d: got wnext=%b wdata=%h required %b %h",
                         i, wnext, m_wdata, e.mask, e.data);
            end
            tick();
            wdata[2*DW +: DW] = 16'h1111 * 16'(i + 2);
        end
        m_wnext = 1'b0;
        m_done = 1'b1; tick(); m_done = 1'b0;
        n_vec++;
        if ({wnext, m_wdata} !== '0) begin
            n_err++;
            $display("FAIL write_idle_wdata: got wnext=%b wdata=%h required 0", wnext, m_wdata);
        end
        we = 3'b000;
    endtask

    task automatic test_ack_done();
        logic [2:0] g;
        addr[AW +: AW] = 24'h000050;
        len[LW +: LW]  = 8'd1;
        req = 3'b010;
        gq.push_back(3'b010);
        gq.push_back(3'b001);
        tick();
        n_vec++;
        if (m_req !== 1'b1) begin
            n_err++;
            $display("FAIL ackdone_req: got %b required 1", m_req);
        end
        m_ack = 1'b1; m_done = 1'b1; tick(); m_ack = 1'b0; m_done = 1'b0;
        pop_grant(g);
        n_vec++;
        if ({gnt, m_req} !== {g, 1'b0}) begin
            n_err++;
            $display("FAIL ackdone_gnt: got gnt=%b req=%b required %b 0", gnt, m_req, g);
        end
        req = 3'b001;
        addr[0 +: AW] = 24'h000070;
        tick();
        n_vec++;
        if ({gnt, m_req, m_addr} !== {3'b000, 1'b1, 24'h000070}) begin
            n_err++;
            $display("FAIL ackdone_next: got gnt=%b req=%b addr=%h required 000 1 000070",
                     gnt, m_req, m_addr);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL ackdone_gnt_next: got %b required %b", gnt, g);
        end
        req = 3'b000;
        m_done = 1'b1; tick(); m_done = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] g;
        addr[AW +: AW] = 24'h000060;
        len[LW +: LW]  = 8'd0;
        req = 3'b010;
        gq.push_back(3'b010);
        gq.push_back(3'b010);
        tick();
        n_vec++;
        if ({m_req, m_len} !== {1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL rstmid_cmd: got req=%b len=%h required 1 00", m_req, m_len);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL rstmid_gnt: got %b required %b", gnt, g);
        end
        // a fresh request from port 1 is pending behind the long burst
        addr[AW +: AW] = 24'h000061;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 16'hB000;
        #1;
        n_vec++;
        if (rvalid !== 3'b010) begin
            n_err++;
            $display("FAIL rstmid_rvalid: got %b required 010", rvalid);
        end
        tick();
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m_req, gnt, rvalid} !== 7'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got req=%b gnt=%b rvalid=%b required 0", m_req, gnt, rvalid);
        end
        m_rvalid = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        n_vec++;
        if ({m_req, m_addr} !== {1'b1, 24'h000061}) begin
            n_err++;
            $display("FAIL rstmid_resume: got req=%b addr=%h required 1 000061", m_req, m_addr);
        end
        m_ack = 1'b1; tick(); m_ack = 1'b0;
        pop_grant(g);
        n_vec++;
        if (gnt !== g) begin
            n_err++;
            $display("FAIL rstmid_gnt_resume: got %b required %b", gnt, g);
        end
        req = 3'b000;
        m_done = 1'b1; tick(); m_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_read();
        test_idle_strobe();
        test_write();
        test_ack_done();
        test_reset_mid_burst();
        n_vec++;
        if ((gq.size() + sb.size()) != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", gq.size() + sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
